cfg_bus_arbiter: RTL

//  Shares the single register-bus port (bus_req/bus_addr/bus_ready/...) between NUM_REQ requesters
//  (e.g. AXI4-Lite slave, debug/JTAG bridge, init sequencer). Round-robin grant, one outstanding

---
 rtl/cfg_bus_arbiter.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/cfg_bus_arbiter.sv
// cfg_bus_arbiter: shares one register-bus port between NUM_REQ requesters using round-robin grant, with a per-access timeout.
// Latency: req_valid seen in IDLE -> bus_req next cycle -> rsp_done the cycle after bus_ready (2 cycles minimum).
// Backpressure: one access in flight; the other requesters hold req_valid until their own rsp_done pulse.
//
// Ports:
//   S_AXI_clk / S_AXI_rst_n   clock, asynchronous active-low reset
//   req_*                     packed per-requester request (port i at [i*W +: W]); held until rsp_done[i]
//   rsp_done/rsp_rd_data/rsp_err  one-cycle completion pulse to the granted port, with data/error
//   busy, grant_idx           arbiter activity and current/last granted port
//   bus_*                     register-bus master side; bus_req is a single-cycle strobe
module cfg_bus_arbiter #(
    parameter int NUM_REQ        = 2,
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                        S_AXI_clk,
    input  logic                        S_AXI_rst_n,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ-1:0]          req_is_wr,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]   req_wr_data,
    input  logic [NUM_REQ*DATA_W/8-1:0] req_wr_strobe,
    output logic [NUM_REQ-1:0]          rsp_done,
    output logic [DATA_W-1:0]           rsp_rd_data,
    output logic                        rsp_err,
    output logic                        busy,
    output logic [$clog2(NUM_REQ)-1:0]  grant_idx,
    output logic                        bus_req,
    output logic                        bus_req_is_wr,
    output logic [ADDR_W-1:0]           bus_addr,
    output logic [DATA_W-1:0]           bus_wr_data,
    output logic [DATA_W/8-1:0]         bus_wr_strobe,
    input  logic                        bus_ready,
    input  logic [DATA_W-1:0]           bus_rd_data,
    input  logic                        bus_err
);

    localparam int GW     = $clog2(NUM_REQ);
    localparam int STRB_W = DATA_W / 8;
    localparam int TO_W   = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [TO_W-1:0] TO_LIM = TO_W'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    // Latched copy of the granted request; drives the bus for the whole access.
    typedef struct packed {
        logic              is_wr;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic [STRB_W-1:0] strb;
    } hdr_t;

    state_t              state;
    hdr_t                hdr_q;
    hdr_t                sel_hdr;
    logic [GW-1:0]       last_grant;
    logic [GW-1:0]       cand;
    logic [GW-1:0]       sel_idx;
    logic                sel_vld;
    logic [TO_W-1:0]     to_cnt;
    logic [NUM_REQ-1:0]  grant_oh;

    // Round-robin: scan upward from the port after the last winner, wrapping.
    always_comb begin
        sel_vld = 1'b0;
        sel_idx = '0;
        cand    = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = GW'((int'(last_grant) + i) % NUM_REQ);
            if (!sel_vld && req_valid[cand]) begin
                sel_vld = 1'b1;
                sel_idx = cand;
            end
        end
    end

    // Write data/strobe are zeroed for reads so the bus never sees stale write payload.
    always_comb begin
        sel_hdr       = '0;
        sel_hdr.is_wr = req_is_wr[sel_idx];
        sel_hdr.addr  = req_addr[int'(sel_idx)*ADDR_W +: ADDR_W];
        if (req_is_wr[sel_idx]) begin
            sel_hdr.data = req_wr_data[int'(sel_idx)*DATA_W +: DATA_W];
            sel_hdr.strb = req_wr_strobe[int'(sel_idx)*STRB_W +: STRB_W];
        end
    end

    assign grant_oh = NUM_REQ'(1) << grant_idx;

    always_ff @(posedge S_AXI_clk or negedge S_AXI_rst_n) begin
        if (!S_AXI_rst_n) begin
            state       <= S_IDLE;
            hdr_q       <= '0;
            last_grant  <= GW'(NUM_REQ - 1);
            grant_idx   <= '0;
            bus_req     <= 1'b0;
            rsp_done    <= '0;
            rsp_rd_data <= '0;
            rsp_err     <= 1'b0;
            to_cnt      <= '0;
        end else begin
            bus_req  <= 1'b0;
            rsp_done <= '0;
            case (state)
                S_IDLE: begin
                    if (sel_vld) begin
                        hdr_q      <= sel_hdr;
                        grant_idx  <= sel_idx;
                        last_grant <= sel_idx;
                        bus_req    <= 1'b1;
                        to_cnt     <= '0;
                        state      <= S_ISSUE;
                    end
                end
                S_ISSUE, S_WAIT: begin
                    // bus_ready takes precedence over a timeout expiring in the same cycle.
                    if (bus_ready) begin
                        rsp_rd_data <= hdr_q.is_wr ? '0 : bus_rd_data;
                        rsp_err     <= bus_err;
                        rsp_done    <= grant_oh;
                        state       <= S_RESP;
                    end else if ((TIMEOUT_CYCLES != 0) && (to_cnt == TO_LIM)) begin
                        rsp_rd_data <= '0;
                        rsp_err     <= 1'b1;
                        rsp_done    <= grant_oh;
                        state       <= S_RESP;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                        state  <= S_WAIT;
                    end
                end
                S_RESP: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy          = (state != S_IDLE);
    assign bus_req_is_wr = hdr_q.is_wr;
    assign bus_addr      = hdr_q.addr;
    assign bus_wr_data   = hdr_q.data;
    assign bus_wr_strobe = hdr_q.strb;

endmodule
